// File: rtl/fp_add_sequencer.sv
// Multi-cycle binary32 adder: align, signed add, then one-bit-per-cycle normalize.
// Reduced IEEE handling: no NaN or denormals, truncation rounding.
module fp_add_sequencer #(
   parameter int unsigned MANT_W    = 23,
   parameter int unsigned EXP_W     = 8,
   parameter int unsigned MAX_ALIGN = 25
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [EXP_W+MANT_W:0]    A,
   input  logic [EXP_W+MANT_W:0]    B,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [EXP_W+MANT_W:0]    Sum,
   output logic                     busy
);

   localparam int unsigned W = 1 + EXP_W + MANT_W;
   localparam int unsigned M = MANT_W + 1;
   localparam logic [EXP_W-1:0] EXP_MAX   = '1;
   localparam logic [EXP_W-1:0] ALIGN_LIM = EXP_W'(MAX_ALIGN);

   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

   state_t           state, state_nx;
   logic [W-1:0]     a_q, a_nx, b_q, b_nx;
   logic             sign_q, sign_nx, sub_q, sub_nx;
   logic [EXP_W-1:0] exp_q, exp_nx;
   logic [M-1:0]     ml_q, ml_nx, ms_q, ms_nx, mant_q, mant_nx;
   logic [W-1:0]     sum_q, sum_nx;
   logic             ov_q, ov_nx;

   logic             a_big;
   logic [EXP_W-1:0] exp_l, exp_s, diff, exp_dec;
   logic [M-1:0]     m_l, m_s, shl;
   logic [M:0]       sum_raw, sum_adj;
   logic [EXP_W:0]   exp_w;

   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign out_valid = ov_q;
   assign Sum       = sum_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         a_q    <= '0;
         b_q    <= '0;
         sign_q <= 1'b0;
         sub_q  <= 1'b0;
         exp_q  <= '0;
         ml_q   <= '0;
         ms_q   <= '0;
         mant_q <= '0;
         sum_q  <= '0;
         ov_q   <= 1'b0;
      end else begin
         state  <= state_nx;
         a_q    <= a_nx;
         b_q    <= b_nx;
         sign_q <= sign_nx;
         sub_q  <= sub_nx;
         exp_q  <= exp_nx;
         ml_q   <= ml_nx;
         ms_q   <= ms_nx;
         mant_q <= mant_nx;
         sum_q  <= sum_nx;
         ov_q   <= ov_nx;
      end
   end

   // Datapath terms for each stage; only the active stage's terms are consumed.
   always_comb begin
      a_big   = (a_q[W-2:0] >= b_q[W-2:0]);
      exp_l   = a_big ? a_q[W-2:MANT_W] : b_q[W-2:MANT_W];
      exp_s   = a_big ? b_q[W-2:MANT_W] : a_q[W-2:MANT_W];
      m_l     = a_big ? {1'b1, a_q[MANT_W-1:0]} : {1'b1, b_q[MANT_W-1:0]};
      m_s     = a_big ? {1'b1, b_q[MANT_W-1:0]} : {1'b1, a_q[MANT_W-1:0]};
      if (exp_l == '0) m_l = '0;
      if (exp_s == '0) m_s = '0;
      diff    = exp_l - exp_s;

      sum_raw = sub_q ? ({1'b0, ml_q} - {1'b0, ms_q}) : ({1'b0, ml_q} + {1'b0, ms_q});
      sum_adj = sum_raw;
      exp_w   = {1'b0, exp_q};
      if (!sub_q && sum_raw[M]) begin
         sum_adj = sum_raw >> 1;
         exp_w   = exp_w + (EXP_W+1)'(1);
      end

      shl     = mant_q << 1;
      exp_dec = exp_q - EXP_W'(1);
   end

   always_comb begin
      state_nx = state;
      a_nx     = a_q;
      b_nx     = b_q;
      sign_nx  = sign_q;
      sub_nx   = sub_q;
      exp_nx   = exp_q;
      ml_nx    = ml_q;
      ms_nx    = ms_q;
      mant_nx  = mant_q;
      sum_nx   = sum_q;
      ov_nx    = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               a_nx     = A;
               b_nx     = B;
               state_nx = ALIGN;
            end
         end
         ALIGN: begin
            sign_nx  = a_big ? a_q[W-1] : b_q[W-1];
            sub_nx   = a_q[W-1] ^ b_q[W-1];
            exp_nx   = exp_l;
            ml_nx    = m_l;
            ms_nx    = (diff >= ALIGN_LIM) ? '0 : (m_s >> diff);
            state_nx = ADD;
         end
         ADD: begin
            if (sum_adj == '0) begin
               sum_nx   = '0;
               state_nx = DONE;
            end else if (exp_w >= {1'b0, EXP_MAX}) begin
               sum_nx   = {sign_q, EXP_MAX, {MANT_W{1'b0}}};
               state_nx = DONE;
            end else if (sum_adj[MANT_W]) begin
               sum_nx   = {sign_q, exp_w[EXP_W-1:0], sum_adj[MANT_W-1:0]};
               state_nx = DONE;
            end else begin
               mant_nx  = sum_adj[M-1:0];
               exp_nx   = exp_w[EXP_W-1:0];
               state_nx = NORM;
            end
         end
         NORM: begin
            mant_nx = shl;
            exp_nx  = exp_dec;
            if (exp_dec == '0) begin
               sum_nx   = '0;
               state_nx = DONE;
            end else if (shl[MANT_W]) begin
               sum_nx   = {sign_q, exp_dec, shl[MANT_W-1:0]};
               state_nx = DONE;
            end
         end
         DONE: begin
            // out_valid is registered: Sum settles on DONE entry and is offered
            // from the following cycle, so the handshake only completes once valid.
            if (ov_q && out_ready) begin
               state_nx = IDLE;
            end else begin
               ov_nx = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Randomized and directed checks of fp_add_sequencer against an arithmetic reference model.
module tb_fp_add_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] Sum;
   logic        busy;

   int passed = 0;
   int total  = 0;

   fp_add_sequencer #(.MANT_W(23), .EXP_W(8), .MAX_ALIGN(25)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
      .Sum(Sum), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference: exact integer mantissa arithmetic with truncating alignment,
   // then count the normalization steps one bit at a time.
   function automatic void ref_add(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] s, output int shifts);
      logic [31:0] big, sml;
      int el, es, e, d;
      longint ml, ms, r;
      if (a[30:0] >= b[30:0]) begin big = a; sml = b; end
      else begin big = b; sml = a; end
      el = int'(big[30:23]);
      es = int'(sml[30:23]);
      ml = (el == 0) ? 0 : 64'd8388608 + longint'(big[22:0]);
      ms = (es == 0) ? 0 : 64'd8388608 + longint'(sml[22:0]);
      d  = el - es;
      ms = (d >= 25) ? 0 : ms / (longint'(1) << d);
      r  = (a[31] != b[31]) ? ml - ms : ml + ms;
      e  = el;
      shifts = 0;
      if (r >= 64'd16777216) begin r = r / 2; e = e + 1; end
      if (r == 0) s = 32'h0;
      else if (e >= 255) s = {big[31], 8'hFF, 23'h0};
      else begin
         while (r < 64'd8388608) begin
            r = r * 2; e = e - 1; shifts++;
            if (e == 0) break;
         end
         s = (e == 0) ? 32'h0 : {big[31], e[7:0], r[22:0]};
      end
   endfunction

   // Drives one transaction from IDLE; lat counts edges after accept until out_valid.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] s, output int lat, output bit hs_bad);
      hs_bad = 1'b0;
      lat = 0;
      A = a; B = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; A = $urandom; B = $urandom;
      while (out_valid !== 1'b1 && lat < 60) begin
         if (in_ready !== 1'b0 || busy !== 1'b1) hs_bad = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      s = Sum;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      total++;
      if ({in_ready, out_valid, busy} !== 3'b100 || Sum !== 32'h0) begin
         $display("FAIL reset: in_ready/out_valid/busy=%b Sum=%h, required 100 Sum=00000000",
                  {in_ready, out_valid, busy}, Sum);
      end else passed++;
   endtask

   task automatic test_directed;
      logic [31:0] va[7] = '{32'h3F800000, 32'h40400000, 32'hBF800000, 32'h3FC00000,
                             32'h3FC00000, 32'h3F800000, 32'h7F7FFFFF};
      logic [31:0] vb[7] = '{32'h3F800000, 32'hBF800000, 32'h40400000, 32'hBFA00000,
                             32'hBFC00000, 32'h30800000, 32'h7F7FFFFF};
      logic [31:0] vs[7] = '{32'h40000000, 32'h40000000, 32'h40000000, 32'h3E800000,
                             32'h00000000, 32'h3F800000, 32'h7F800000};
      int          vl[7] = '{3, 3, 3, 5, 3, 3, 3};
      logic [31:0] s;
      int lat;
      bit hs_bad;
      for (int unsigned i = 0; i < 7; i++) begin
         run_op(va[i], vb[i], s, lat, hs_bad);
         total++;
         if (s !== vs[i]) $display("FAIL directed_sum[%0d]: got %h, required %h", i, s, vs[i]);
         else passed++;
         total++;
         if (lat != vl[i]) $display("FAIL directed_latency[%0d]: got %0d, required %0d", i, lat, vl[i]);
         else passed++;
         total++;
         if (hs_bad) $display("FAIL directed_busy[%0d]: in_ready/busy wrong while in flight, required 0/1", i);
         else passed++;
      end
   endtask

   task automatic test_flush;
      logic [31:0] s;
      int lat;
      bit hs_bad;
      // Near-cancellation at exponent 2: the second shift would reach exponent 0.
      run_op(32'h01000001, 32'h81000000, s, lat, hs_bad);
      total++;
      if (s !== 32'h0 || lat != 5) $display("FAIL flush: got Sum=%h lat=%0d, required 00000000 lat=5", s, lat);
      else passed++;
   endtask

   task automatic test_random;
      logic [31:0] a, b, s, exp_s;
      int lat, shifts, ea, eb;
      bit hs_bad;
      for (int unsigned i = 0; i < 60; i++) begin
         ea = (i % 4 == 0) ? $urandom_range(1, 30) : $urandom_range(1, 254);
         case (i % 3)
            0: eb = $urandom_range(1, 254);
            1: eb = ea;
            default: eb = (ea > 2) ? ea - $urandom_range(0, 2) : ea;
         endcase
         a = {1'($urandom), 8'(ea), 23'($urandom)};
         b = {(i % 3 == 0) ? 1'($urandom) : ~a[31], 8'(eb), 23'($urandom)};
         if (i % 6 == 1) b[22:8] = a[22:8];
         ref_add(a, b, exp_s, shifts);
         run_op(a, b, s, lat, hs_bad);
         total++;
         if (s !== exp_s) $display("FAIL random_sum[%0d] %h+%h: got %h, required %h", i, a, b, s, exp_s);
         else passed++;
         total++;
         if (lat != 3 + shifts) $display("FAIL random_latency[%0d] %h+%h: got %0d, required %0d",
                                         i, a, b, lat, 3 + shifts);
         else passed++;
      end
   endtask

   task automatic test_stall;
      logic [31:0] s0, exp_s;
      int n, shifts;
      ref_add(32'h40A00000, 32'h3F000000, exp_s, shifts);
      A = 32'h40A00000; B = 32'h3F000000; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (out_valid !== 1'b1 && n < 60) begin @(posedge clk); #1; n++; end
      s0 = Sum;
      total++;
      if (out_valid !== 1'b1 || s0 !== exp_s) $display("FAIL stall_first: out_valid=%b Sum=%h, required 1 %h",
                                                       out_valid, s0, exp_s);
      else passed++;
      for (int unsigned i = 0; i < 5; i++) begin
         in_valid = i[0]; A = $urandom; B = $urandom;
         @(posedge clk); #1;
         total++;
         if (out_valid !== 1'b1 || Sum !== exp_s || in_ready !== 1'b0)
            $display("FAIL stall_hold[%0d]: out_valid=%b Sum=%h in_ready=%b, required 1 %h 0",
                     i, out_valid, Sum, in_ready, exp_s);
         else passed++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || Sum !== exp_s)
         $display("FAIL stall_release: out_valid=%b in_ready=%b busy=%b Sum=%h, required 0 1 0 %h",
                  out_valid, in_ready, busy, Sum, exp_s);
      else passed++;
   endtask

   task automatic test_reset_norm;
      logic [31:0] s;
      int lat;
      bit hs_bad;
      A = 32'h3FC00000; B = 32'hBFA00000; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (busy !== 1'b1 || out_valid !== 1'b0 || Sum === 32'h0)
         $display("FAIL rst_norm_pre: busy=%b out_valid=%b Sum=%h, required 1 0 nonzero", busy, out_valid, Sum);
      else passed++;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      total++;
      if (out_valid !== 1'b0 || Sum !== 32'h0 || in_ready !== 1'b1 || busy !== 1'b0)
         $display("FAIL rst_norm: out_valid=%b Sum=%h in_ready=%b busy=%b, required 0 00000000 1 0",
                  out_valid, Sum, in_ready, busy);
      else passed++;
      run_op(32'h3F800000, 32'h3F800000, s, lat, hs_bad);
      total++;
      if (s !== 32'h40000000 || lat != 3) $display("FAIL rst_recover: got Sum=%h lat=%0d, required 40000000 lat=3", s, lat);
      else passed++;
   endtask

   initial begin
      test_reset;
      test_directed;
      test_flush;
      test_random;
      test_stall;
      test_reset_norm;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
